// File: rtl/simon_pkg.sv
// Shared Simon definitions: widths, colour codes, LED decode and the player FSM encoding.
package simon_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned COLOR_W = 2;
  localparam int unsigned LED_W   = 4;

  localparam logic [COLOR_W-1:0] GREEN  = 2'd0;
  localparam logic [COLOR_W-1:0] RED    = 2'd1;
  localparam logic [COLOR_W-1:0] YELLOW = 2'd2;
  localparam logic [COLOR_W-1:0] BLUE   = 2'd3;

  // Player FSM encoding, kept as plain constants so legacy blocks can share it.
  typedef logic [2:0] play_state_t;
  localparam play_state_t StIdle  = 3'd0;
  localparam play_state_t StFetch = 3'd1;
  localparam play_state_t StLatch = 3'd2;
  localparam play_state_t StOn    = 3'd3;
  localparam play_state_t StOff   = 3'd4;
  localparam play_state_t StDone  = 3'd5;

  // One LED per colour; the board wires green to bit 0 through blue to bit 3.
  function automatic logic [LED_W-1:0] color_onehot(input logic [COLOR_W-1:0] color);
    logic [LED_W-1:0] oh;
    oh = '0;
    case (color)
      GREEN:   oh = 4'b0001;
      RED:     oh = 4'b0010;
      YELLOW:  oh = 4'b0100;
      BLUE:    oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the LED on and off phases.
module phase_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);

  logic [Width-1:0] count_q, count_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires in the last cycle of a phase so the next phase can load on the same edge.
  assign expire_o = (count_q == Width'(1));

endmodule

// File: rtl/sequence_player.sv
// Plays the first round_len colours of the sequence memory on the LEDs, one on/off slot each.
module sequence_player
  import simon_pkg::*;
#(
  parameter int unsigned N          = 10,
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seq_ready_i,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  round_len_i,
  output logic [ADDR_W-1:0]  rd_addr_o,
  input  logic [COLOR_W-1:0] rd_data_i,
  output logic [LED_W-1:0]   led_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned TimerMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [ADDR_W-1:0] LenMax = ADDR_W'(N);

  play_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timer_load;
  logic [TimerW-1:0]  timer_val;
  logic               timer_expire;

  phase_timer #(
    .Width (TimerW)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expire_o   (timer_expire)
  );

  // Playback sequencing: fetch, latch colour, hold on, hold off, advance or finish.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    led_d      = led_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i && seq_ready_i) begin
          busy_d  = 1'b1;
          idx_d   = '0;
          len_d   = (round_len_i > LenMax) ? LenMax : round_len_i;
          state_d = (round_len_i == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        // Memory samples rd_addr on this edge; data is usable in LATCH.
        state_d = StLatch;
      end
      StLatch: begin
        led_d      = color_onehot(rd_data_i);
        timer_load = 1'b1;
        timer_val  = TimerW'(ON_CYCLES);
        state_d    = StOn;
      end
      StOn: begin
        if (timer_expire) begin
          led_d      = '0;
          timer_load = 1'b1;
          timer_val  = TimerW'(OFF_CYCLES);
          state_d    = StOff;
        end
      end
      StOff: begin
        if (timer_expire) begin
          if (idx_q == len_q - ADDR_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        // A zero-length round arrives here still busy and raises done one cycle late.
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset darkens the LEDs immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd_addr_o = idx_q;
  assign led_o     = led_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: vector table plus event scoreboard, and hand-written corner cases.
module tb_sequence_player;

  localparam int N   = 10;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = 2 + ON + OFF;

  localparam int LedRise  = 0;
  localparam int LedFall  = 1;
  localparam int BusyRise = 2;
  localparam int BusyFall = 3;
  localparam int DoneRise = 4;
  localparam int DoneFall = 5;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] val;
    logic [3:0] addr;
  } ev_t;

  typedef struct {
    logic [3:0] round_len;
    logic       seq_ready;
    int         flashes;
    int         latency;  // start edge to done edge; -1 means not accepted
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       seq_ready_i;
  logic       start_i;
  logic [3:0] round_len_i;
  logic [3:0] rd_addr_o;
  logic [1:0] rd_data_i;
  logic [3:0] led_o;
  logic       busy_o;
  logic       done_o;

  logic [1:0] mem [16];

  int         cyc;
  int         total;
  int         bad;
  int         flashes;
  int         last_done;
  logic [3:0] prev_led;
  logic       prev_busy;
  logic       prev_done;
  ev_t        exp_q[$];
  vec_t       vecs[7];

  sequence_player #(
    .N          (N),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seq_ready_i (seq_ready_i),
    .start_i     (start_i),
    .round_len_i (round_len_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .led_o       (led_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read sequence memory.
  always @(posedge clk) rd_data_i <= mem[rd_addr_o];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic observe(input int kind, input logic [3:0] val, input logic [3:0] addr);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d at cycle %0d led=%b, required no event",
               kind, cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == LedRise && (e.val != val || e.addr != addr))) begin
        bad++;
        $display("FAIL event: got kind=%0d cyc=%0d led=%b addr=%0d, required kind=%0d cyc=%0d led=%b addr=%0d",
                 kind, cyc, val, addr, e.kind, e.cyc, e.val, e.addr);
      end
    end
  endtask

  // Advance one cycle and compare any output edges against the scoreboard.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (led_o != 4'b0000 && led_o != prev_led) begin
      flashes++;
      observe(LedRise, led_o, rd_addr_o);
    end
    if (led_o == 4'b0000 && prev_led != 4'b0000) observe(LedFall, 4'b0000, 4'd0);
    if (busy_o && !prev_busy) observe(BusyRise, 4'b0000, 4'd0);
    if (!busy_o && prev_busy) observe(BusyFall, 4'b0000, 4'd0);
    if (done_o && !prev_done) begin
      last_done = cyc;
      observe(DoneRise, 4'b0000, 4'd0);
    end
    if (!done_o && prev_done) observe(DoneFall, 4'b0000, 4'd0);
    prev_led  = led_o;
    prev_busy = busy_o;
    prev_done = done_o;
  endtask

  function automatic void push_ev(input int kind, input int c, input logic [3:0] val,
                                  input logic [3:0] addr);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    e.addr = addr;
    exp_q.push_back(e);
  endfunction

  // Expected output edges for a playback whose start is sampled at edge t.
  function automatic void push_play(input int t, input int rl);
    int len;
    len = (rl > N) ? N : rl;
    push_ev(BusyRise, t, 4'b0000, 4'd0);
    if (len == 0) begin
      push_ev(BusyFall, t + 1, 4'b0000, 4'd0);
      push_ev(DoneRise, t + 1, 4'b0000, 4'd0);
      push_ev(DoneFall, t + 2, 4'b0000, 4'd0);
    end else begin
      for (int k = 0; k < len; k++) begin
        push_ev(LedRise, t + k * P + 2, 4'b0001 << mem[k], 4'(k));
        push_ev(LedFall, t + k * P + 2 + ON, 4'b0000, 4'd0);
      end
      push_ev(BusyFall, t + len * P, 4'b0000, 4'd0);
      push_ev(DoneRise, t + len * P, 4'b0000, 4'd0);
      push_ev(DoneFall, t + len * P + 1, 4'b0000, 4'd0);
    end
  endfunction

  // Wait (bounded) for done, then check latency and flash count.
  task automatic finish_case(input string name, input int t, input int f0, input vec_t v);
    for (int i = 0; i < v.latency + 20 && last_done < 0; i++) tick();
    chk({name, "_done_latency"}, last_done - t, v.latency);
    tick();
    chk({name, "_flashes"}, flashes - f0, v.flashes);
  endtask

  task automatic run_case(input string name, input vec_t v);
    int t;
    int f0;
    bit quiet;
    seq_ready_i = v.seq_ready;
    round_len_i = v.round_len;
    start_i     = 1'b1;
    t           = cyc + 1;
    f0          = flashes;
    last_done   = -1;
    if (v.seq_ready) push_play(t, int'(v.round_len));
    tick();
    start_i = 1'b0;
    if (v.latency < 0) begin
      quiet = 1'b1;
      repeat (50) begin
        tick();
        if (busy_o || led_o != 4'b0000) quiet = 1'b0;
      end
      chk({name, "_stays_idle"}, int'(quiet), 1);
      chk({name, "_flashes"}, flashes - f0, v.flashes);
    end else begin
      finish_case(name, t, f0, v);
    end
  endtask

  initial begin
    int   t;
    int   f0;
    vec_t v3;

    mem = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3,
            2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[0] = '{4'd3,  1'b1, 3,  21};
    vecs[1] = '{4'd4,  1'b0, 0,  -1};
    vecs[2] = '{4'd1,  1'b1, 1,  7};
    vecs[3] = '{4'd0,  1'b1, 0,  1};
    vecs[4] = '{4'd15, 1'b1, 10, 70};
    vecs[5] = '{4'd10, 1'b1, 10, 70};
    vecs[6] = '{4'd2,  1'b1, 2,  14};
    v3 = vecs[0];

    cyc = 0; total = 0; bad = 0; flashes = 0; last_done = -1;
    prev_led = 4'b0000; prev_busy = 1'b0; prev_done = 1'b0;
    reset = 1'b1; seq_ready_i = 1'b0; start_i = 1'b0; round_len_i = 4'd0;
    repeat (3) tick();
    chk("reset_led", int'(led_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_rd_addr", int'(rd_addr_o), 0);
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) run_case($sformatf("vec%0d", i), vecs[i]);

    // Second start during entry 1, with seq_ready dropped and round_len changed.
    seq_ready_i = 1'b1; round_len_i = 4'd3; start_i = 1'b1;
    t = cyc + 1; f0 = flashes; last_done = -1;
    push_play(t, 3);
    tick();
    start_i = 1'b0;
    while (cyc < t + P + 3) tick();
    start_i = 1'b1; round_len_i = 4'd1;
    tick();
    start_i = 1'b0; seq_ready_i = 1'b0; round_len_i = 4'd7;
    finish_case("restart_ignored", t, f0, v3);
    seq_ready_i = 1'b1;
    tick();

    // Reset in the middle of entry 2's on-time.
    round_len_i = 4'd3; start_i = 1'b1;
    t = cyc + 1;
    push_play(t, 3);
    tick();
    start_i = 1'b0;
    while (cyc < t + 2 * P + 3) tick();
    chk("pre_reset_led", int'(led_o), 4'b1000);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_led", int'(led_o), 0);
    chk("async_reset_busy", int'(busy_o), 0);
    chk("async_reset_rd_addr", int'(rd_addr_o), 0);
    chk("async_reset_done", int'(done_o), 0);
    exp_q.delete();
    prev_led = led_o; prev_busy = busy_o; prev_done = done_o;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    run_case("replay_after_reset", v3);

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
# sequence_player

Plays back the first `round_len` entries of the Simon sequence memory filled by the loader stage, lighting one LED per entry for a fixed on-time followed by a fixed off-gap. It sits directly downstream of the loader and the sequence memory, and upstream of the LED pins and the input-checking stage. It is gated by the loader's completion flag. It reports completion with a one-cycle `done` pulse.

## Interface
- `N`, 10: sequence depth; legal `round_len` range is 1..N.
- `ON_CYCLES`, 25_000_000: cycles each LED stays lit; minimum 1.
- `OFF_CYCLES`, 12_500_000: dark cycles after each LED; minimum 1.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `seq_ready`  in  1  loader finished; level signal.
- `start`  in  1  request playback; single-cycle pulse.
- `round_len`  in  4  number of entries to play; sampled with `start`.
- `rd_addr`  out  4  sequence memory read address.
- `rd_data`  in  2  memory read data; synchronous read, valid the cycle after `rd_addr` changes.
- `led`  out  4  one-hot colour output; 0 when dark.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Reset values: `rd_addr`=0, `led`=0, `busy`=0, `done`=0, FSM=IDLE, all counters=0.
- FSM states: IDLE, FETCH, LATCH, ON, OFF, DONE.
- IDLE: `start`=1 and `seq_ready`=1 latches `len`, sets idx=0, `rd_addr`=0, `busy`=1, and moves to FETCH. Otherwise the FSM stays in IDLE.
- `len` clamp: `round_len`>N is clamped to N. `round_len`=0 goes straight to DONE, with no LED activity.
- FETCH: memory registers the address. Next state is LATCH.
- LATCH: `led`<=onehot(`rd_data`) with mapping 0→0001, 1→0010, 2→0100, 3→1000. Timer loads ON_CYCLES. Next state is ON.
- ON: timer decrements. On expiry, `led`<=0, timer loads OFF_CYCLES, next state is OFF.
- OFF: timer decrements. On expiry:
  - if idx==len-1, next state is DONE;
  - otherwise idx++, `rd_addr`<=idx+1, next state is FETCH.
- DONE: `done`=1 for exactly one cycle and `busy`=0. Next state is IDLE.
- `start` while `busy`=1 is ignored and does not restart playback.
- `start` with `seq_ready`=0 is ignored.
- `seq_ready` dropping mid-playback has no effect.
- `round_len` changes after acceptance are ignored.
- Reset asserted mid-playback forces all reset values immediately, including `led`=0 asynchronously. Playback is not resumed after reset.
- Width rules:
  - idx and `rd_addr` are 4 bits and never exceed N-1.
  - Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
  - No wrap-around is reachable.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `start` sampled at edge t; `led` for entry 0 rises after edge t+2.
- Per-entry period P = 2 + ON_CYCLES + OFF_CYCLES.
- Entry k `led` is high after edges t+kP+2 through t+kP+2+ON_CYCLES-1, i.e. exactly ON_CYCLES cycles.
- `done` is high for the one cycle following edge t+len·P. `busy` falls on that same edge.
- `round_len`=0: `done` is high after edge t+1, and `busy` is high for one cycle.
- A new `start` is accepted on the first edge after `done` deasserts, i.e. when the FSM is in IDLE.

## Structure
- Shared package `simon_pkg` holds:
  - `ADDR_W`=4 and `COLOR_W`=2;
  - colour code constants `GREEN`=0, `RED`=1, `YELLOW`=2, `BLUE`=3;
  - function `color_onehot()`;
  - state enum for this FSM.
- The package is shared with the loader, the memory and the input checker.
- One sub-module: `phase_timer`, a loadable down-counter with `load`, `load_val` and `expire` pulse. It is instantiated once and reused for both the ON and OFF phases.

## Test plan
Benches use ON_CYCLES=3 and OFF_CYCLES=2, so P=7. Memory preload is 2,0,3,1.
- `round_len`=3, `start` at edge 10 → `led`=0100 after edges 12–14, 0001 after edges 19–21, 1000 after edges 26–28; `done` high for one cycle after edge 31; `rd_addr` sequence is 0,1,2.
- `start` with `seq_ready`=0 → `busy` stays 0 and `led` stays 0000 for 50 cycles. Then raise `seq_ready`, pulse `start` with `round_len`=1 → `led`=0100 after start+2; `done` after start+7.
- `round_len`=0 → no LED activity; `busy`=1 for one cycle; `done` pulse one cycle after `start`.
- `round_len`=15 → clamped to N=10; exactly 10 LED flashes; `done` after start+70.
- Second `start` pulse during ON of entry 1 → ignored; sequence and `done` timing are identical to the first scenario.
- Reset asserted mid-ON of entry 2 → `led`=0000, `busy`=0 and `rd_addr`=0 immediately. After release, a fresh `start` replays from entry 0.
